// File: rtl/ram_copy_dma.sv
// +--------------------------------------------------------------------------+
// | ram_copy_dma                                                             |
// | Word copy engine driving a dual-port byte RAM, one word per cycle.       |
// | Optional fill mode (constant word write) under `RAM_COPY_FILL_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ram_copy_dma #(
  parameter int DW      = 8,
  parameter int AW      = 7,
  parameter int MEM_NUM = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   src_addr_i,
  input  logic [AW-1:0]   dst_addr_i,
  input  logic [AW-2:0]   len_i,
`ifdef RAM_COPY_FILL_EN
  input  logic            fill_i,
  input  logic [4*DW-1:0] fill_data_i,
`endif
  output logic            busy_o,
  output logic            done_o,
  output logic            ren_o,
  output logic [AW-1:0]   r_addr_o,
  input  logic [4*DW-1:0] r_data_i,
  output logic            wen_o,
  output logic [AW-1:0]   w_addr_o,
  output logic [4*DW-1:0] w_data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  if (MEM_NUM != (1 << AW)) begin : g_depth_check
    $error("ram_copy_dma: MEM_NUM must equal 2**AW");
  end

  state_t          r_state;
  logic [AW-1:0]   r_src;
  logic [AW-1:0]   r_dst;
  logic [AW-2:0]   r_len;
  logic [AW-2:0]   r_rc;
  logic [AW-2:0]   r_wc;
  logic [AW-1:0]   r_raddr;
  logic [AW-1:0]   r_waddr;
  logic            r_ren;
  logic            r_wen;
  logic            r_busy;
  logic            r_done;

  logic            w_fill;
  logic            w_fill_cmd;
  logic [AW-1:0]   w_rd_addr;
  logic [AW-1:0]   w_wr_addr;

  // Counters hold the index of the next access; byte offset is index*4, wrapping.
  assign w_rd_addr = r_src + {r_rc[AW-3:0], 2'b00};
  assign w_wr_addr = r_dst + {r_wc[AW-3:0], 2'b00};

`ifdef RAM_COPY_FILL_EN
  logic            r_fill;
  logic [4*DW-1:0] r_fill_data;

  assign w_fill     = r_fill;
  assign w_fill_cmd = fill_i;
  assign w_data_o   = r_wen ? (r_fill ? r_fill_data : r_data_i) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill      <= 1'b0;
      r_fill_data <= '0;
    end else if ((r_state != S_RUN) && start) begin
      r_fill      <= fill_i;
      r_fill_data <= fill_data_i;
    end
  end
`else
  assign w_fill     = 1'b0;
  assign w_fill_cmd = 1'b0;
  assign w_data_o   = r_wen ? r_data_i : '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_rc    <= '0;
      r_wc    <= '0;
      r_raddr <= '0;
      r_waddr <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        // The done cycle also accepts a new command so back-to-back starts work.
        S_IDLE, S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
          if (start) begin
            r_src <= src_addr_i;
            r_dst <= dst_addr_i;
            r_len <= len_i;
            r_rc  <= '0;
            r_wc  <= '0;
            if (len_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              if (w_fill_cmd) begin
                r_wen   <= 1'b1;
                r_waddr <= dst_addr_i;
                r_wc    <= {{(AW-2){1'b0}}, 1'b1};
              end else begin
                r_ren   <= 1'b1;
                r_raddr <= src_addr_i;
                r_rc    <= {{(AW-2){1'b0}}, 1'b1};
              end
            end
          end
        end

        S_RUN: begin
          if ((w_fill || r_wen) && (r_wc == r_len)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
          end else if (w_fill) begin
            r_waddr <= w_wr_addr;
            r_wc    <= r_wc + 1'b1;
          end else begin
            r_ren <= (r_rc < r_len);
            if (r_rc < r_len) begin
              r_raddr <= w_rd_addr;
              r_rc    <= r_rc + 1'b1;
            end
            // A read issued this cycle returns data next cycle, which is written then.
            r_wen <= r_ren;
            if (r_ren) begin
              r_waddr <= w_wr_addr;
              r_wc    <= r_wc + 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign ren_o    = r_ren;
  assign r_addr_o = r_raddr;
  assign wen_o    = r_wen;
  assign w_addr_o = r_waddr;

endmodule

`default_nettype wire

// File: tb/tb_ram_copy_dma.sv
// Directed bench for ram_copy_dma with a behavioural dual-port byte RAM.
`default_nettype none

module tb_ram_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  src = '0;
  logic [6:0]  dst = '0;
  logic [5:0]  len = '0;
  logic        busy, done, ren, wen;
  logic [6:0]  r_addr, w_addr;
  logic [31:0] r_data = '0;
  logic [31:0] w_data;
`ifdef RAM_COPY_FILL_EN
  logic        fill = 1'b0;
  logic [31:0] fill_data = '0;
`endif

  logic        h_we = 1'b0;
  logic [6:0]  h_addr = '0;
  logic [31:0] h_data = '0;
  logic [7:0]  mem [0:127];

  int n_tests = 0;
  int n_fail  = 0;

  int          done_cyc;
  int          ren_cnt;
  int          wen_cnt;
  logic [63:0] busy_mask;
  logic [6:0]  rd_q[$];
  logic [6:0]  wr_q[$];

  always #5 clk = ~clk;

  ram_copy_dma #(.DW(8), .AW(7), .MEM_NUM(128)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .len_i      (len),
`ifdef RAM_COPY_FILL_EN
    .fill_i     (fill),
    .fill_data_i(fill_data),
`endif
    .busy_o     (busy),
    .done_o     (done),
    .ren_o      (ren),
    .r_addr_o   (r_addr),
    .r_data_i   (r_data),
    .wen_o      (wen),
    .w_addr_o   (w_addr),
    .w_data_o   (w_data)
  );

  // RAM read byte, with forwarding of a same-cycle write to the same byte
  function automatic logic [7:0] fwd(input logic [6:0] a);
    logic [7:0] b;
    b = mem[a];
    if (wen)
      for (int j = 0; j < 4; j++)
        if (7'(w_addr + 7'(j)) == a) b = w_data[8*j +: 8];
    return b;
  endfunction

  always @(posedge clk) begin
    if (ren)
      r_data <= {fwd(r_addr + 7'd3), fwd(r_addr + 7'd2), fwd(r_addr + 7'd1), fwd(r_addr)};
    if (wen) begin
      for (int j = 0; j < 4; j++) mem[w_addr + 7'(j)] <= w_data[8*j +: 8];
    end else if (h_we) begin
      for (int j = 0; j < 4; j++) mem[h_addr + 7'(j)] <= h_data[8*j +: 8];
    end
  end

  function automatic logic [31:0] peek(input logic [6:0] a);
    return {mem[a + 7'd3], mem[a + 7'd2], mem[a + 7'd1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    h_we = 1'b1; h_addr = a; h_data = d;
    @(posedge clk);
    #1 h_we = 1'b0;
  endtask

  // Issue one command and record the cycle-by-cycle activity until done_o
  task automatic run_cmd(input string tag, input logic [6:0] s, input logic [6:0] d,
                         input logic [5:0] l);
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    @(posedge clk);
    done_cyc = 0; ren_cnt = 0; wen_cnt = 0; busy_mask = '0;
    rd_q.delete(); wr_q.delete();
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_mask[k] = 1'b1;
      if (ren) begin ren_cnt++; rd_q.push_back(r_addr); end
      if (wen) begin wen_cnt++; wr_q.push_back(w_addr); end
      if (done) begin done_cyc = k; break; end
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, {62'd0, done, busy}, 64'd0);
  endtask

  int n_done;

  initial begin
    // reset state
    #12;
    check("rst_outputs", {busy, done, ren, wen, r_addr, w_addr, w_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++)
      poke(7'(4*i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});

    // basic copy
    run_cmd("copy", 7'd0, 7'd64, 6'd4);
    check("copy_done_cyc", 64'(done_cyc), 64'd6);
    check("copy_busy_mask", busy_mask, 64'h3E);
    check("copy_ren_cnt", 64'(ren_cnt), 64'd4);
    check("copy_wen_cnt", 64'(wen_cnt), 64'd4);
    check("copy_rd_first", 64'(rd_q[0]), 64'd0);
    check("copy_rd_last", 64'(rd_q[3]), 64'd12);
    check("copy_wr_first", 64'(wr_q[0]), 64'd64);
    check("copy_wr_last", 64'(wr_q[3]), 64'd76);
    check("copy_word64", 64'(peek(7'd64)), 64'h03020100);
    check("copy_word68", 64'(peek(7'd68)), 64'h07060504);
    check("copy_word76", 64'(peek(7'd76)), 64'h0F0E0D0C);

    // zero length
    run_cmd("len0", 7'd8, 7'd16, 6'd0);
    check("len0_done_cyc", 64'(done_cyc), 64'd1);
    check("len0_accesses", 64'(ren_cnt + wen_cnt), 64'd0);
    check("len0_busy_mask", busy_mask, 64'd0);
    check("len0_word16", 64'(peek(7'd16)), 64'h13121110);

    // address wrap
    run_cmd("wrap", 7'd120, 7'd0, 6'd2);
    check("wrap_rd0", 64'(rd_q[0]), 64'd120);
    check("wrap_rd1", 64'(rd_q[1]), 64'd124);
    check("wrap_wr0", 64'(wr_q[0]), 64'd0);
    check("wrap_wr1", 64'(wr_q[1]), 64'd4);
    check("wrap_word0", 64'(peek(7'd0)), 64'h7B7A7978);
    check("wrap_word4", 64'(peek(7'd4)), 64'h7F7E7D7C);

    // forward overlap: every destination word ends up as W0
    poke(7'd0, 32'hA0A1A2A3);
    poke(7'd4, 32'hB0B1B2B3);
    poke(7'd8, 32'hC0C1C2C3);
    poke(7'd12, 32'hD0D1D2D3);
    run_cmd("ovl", 7'd0, 7'd4, 6'd3);
    check("ovl_done_cyc", 64'(done_cyc), 64'd5);
    check("ovl_word4", 64'(peek(7'd4)), 64'hA0A1A2A3);
    check("ovl_word8", 64'(peek(7'd8)), 64'hA0A1A2A3);
    check("ovl_word12", 64'(peek(7'd12)), 64'hA0A1A2A3);

    // abort mid-transfer
    for (int i = 0; i < 8; i++) poke(7'(64 + 4*i), 32'hEEEEEEEE);
    @(negedge clk);
    start = 1'b1; src = 7'd32; dst = 7'd64; len = 6'd8;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, ren, wen, r_addr, w_addr, w_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_word64", 64'(peek(7'd64)), 64'h23222120);
    check("abort_word68", 64'(peek(7'd68)), 64'hEEEEEEEE);
    run_cmd("after_abort", 7'd32, 7'd64, 6'd2);
    check("after_abort_done_cyc", 64'(done_cyc), 64'd4);
    check("after_abort_word68", 64'(peek(7'd68)), 64'h27262524);

`ifdef RAM_COPY_FILL_EN
    fill = 1'b1; fill_data = 32'hA5A5A5A5;
    run_cmd("fill", 7'd0, 7'd32, 6'd4);
    fill = 1'b0;
    check("fill_done_cyc", 64'(done_cyc), 64'd5);
    check("fill_ren_cnt", 64'(ren_cnt), 64'd0);
    check("fill_wen_cnt", 64'(wen_cnt), 64'd4);
    check("fill_words", {peek(7'd32) & peek(7'd36), peek(7'd40) & peek(7'd44)},
          64'hA5A5A5A5A5A5A5A5);
    check("fill_word48", 64'(peek(7'd48)), 64'h33323130);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
